// File: rtl/ex_pkg.sv
// Shared definitions for the execute/memory pipeline boundary: buffer
// occupancy states and the default-width result record.
package ex_pkg;

  localparam int unsigned EX_SIZE     = 32;
  localparam int unsigned EX_RD_WIDTH = 5;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  typedef struct packed {
    logic [EX_SIZE-1:0]     S;
    logic                   C;
    logic                   V;
    logic                   N;
    logic                   Z;
    logic [EX_RD_WIDTH-1:0] rd;
    logic                   we;
  } ex_result_t;

endpackage

// File: rtl/ex_result_reg.sv
// One result-record register with asynchronous active-high reset and load
// enable; the record type defaults to the package layout.
import ex_pkg::*;

module ex_result_reg #(
  parameter type entry_t = ex_result_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_buffer.sv
// Two-entry skid buffer between execute and memory stages (main + skid entry).
// Optional flag forwarding is enabled by defining EX_MEM_FLAGS_EN.
import ex_pkg::*;

module ex_mem_skid_buffer #(
  parameter int unsigned size     = 32,
  parameter int unsigned rd_width = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [size-1:0]     in_S,
  input  logic                in_C,
  input  logic                in_V,
  input  logic                in_N,
  input  logic                in_Z,
  input  logic [rd_width-1:0] in_rd,
  input  logic                in_we,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [size-1:0]     out_S,
  output logic                out_C,
  output logic                out_V,
  output logic                out_N,
  output logic                out_Z,
  output logic [rd_width-1:0] out_rd,
  output logic                out_we
);

  // Same field order as ex_result_t, resized to this instance's parameters.
  typedef struct packed {
    logic [size-1:0]     S;
    logic                C;
    logic                V;
    logic                N;
    logic                Z;
    logic [rd_width-1:0] rd;
    logic                we;
  } entry_t;

  state_t state, state_next;
  logic   in_fire, out_fire;
  logic   main_load, skid_load, main_from_skid;
  entry_t in_entry, main_d, main_q, skid_q;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    in_entry.S  = in_S;
    in_entry.rd = in_rd;
    in_entry.we = in_we;
`ifdef EX_MEM_FLAGS_EN
    in_entry.C = in_C;
    in_entry.V = in_V;
    in_entry.N = in_N;
    in_entry.Z = in_Z;
`else
    in_entry.C = 1'b0;
    in_entry.V = 1'b0;
    in_entry.N = 1'b0;
    in_entry.Z = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush overrides every transfer, so no entry loads in a flush cycle.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              state_next = FULL;
              skid_load  = 1'b1;
            end
            2'b01: state_next = EMPTY;
            2'b11: main_load = 1'b1;
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            state_next     = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  ex_result_reg #(.entry_t(entry_t)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  ex_result_reg #(.entry_t(entry_t)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign out_S  = main_q.S;
  assign out_rd = main_q.rd;
  assign out_we = main_q.we & out_valid;

`ifdef EX_MEM_FLAGS_EN
  assign out_C = main_q.C;
  assign out_V = main_q.V;
  assign out_N = main_q.N;
  assign out_Z = main_q.Z;
`else
  logic unused_flags;
  assign unused_flags = ^{in_C, in_V, in_N, in_Z, main_q.C, main_q.V, main_q.N, main_q.Z};
  assign out_C = 1'b0;
  assign out_V = 1'b0;
  assign out_N = 1'b0;
  assign out_Z = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// Scoreboard bench for ex_mem_skid_buffer; accepted inputs are queued and a
// monitor checks every delivered result in order.
module tb_ex_mem_skid_buffer;

`ifdef EX_MEM_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_S;
  logic        in_C, in_V, in_N, in_Z;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_S;
  logic        out_C, out_V, out_N, out_Z;
  logic [4:0]  out_rd;
  logic        out_we;

  logic [41:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ex_mem_skid_buffer #(.size(32), .rd_width(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_S      (in_S),
    .in_C      (in_C),
    .in_V      (in_V),
    .in_N      (in_N),
    .in_Z      (in_Z),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_S     (out_S),
    .out_C     (out_C),
    .out_V     (out_V),
    .out_N     (out_N),
    .out_Z     (out_Z),
    .out_rd    (out_rd),
    .out_we    (out_we)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic [4:0] rd,
                       input logic we, input logic c, input logic ov, input logic n,
                       input logic z);
    in_valid = v;
    in_S     = s;
    in_rd    = rd;
    in_we    = we;
    in_C     = c;
    in_V     = ov;
    in_N     = n;
    in_Z     = z;
  endtask

  // Acceptance side: record what the buffer has taken, discard on flush.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back({in_S, in_C & FL, in_V & FL, in_N & FL, in_Z & FL, in_rd, in_we});
      end
    end
  end

  // Delivery side: every memory-stage handshake must match the queue head.
  always @(negedge clk) begin
    logic [41:0] e;
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got S=0x%0h, required no delivery at %0t", out_S, $time);
      end else begin
        e = exp_q.pop_front();
        chk("delivery", {22'd0, out_S, out_C, out_V, out_N, out_Z, out_rd, out_we}, {22'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_S", out_S, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_rd", out_rd, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back streaming with the consumer always ready.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_out_S0", out_S, 32'h5);
    chk("b2b_in_ready0", in_ready, 1);
    drive(1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("b2b_out_S1", out_S, 32'hFFFF_FFFF);
    chk("b2b_in_ready1", in_ready, 1);
    drive(1'b1, 32'h8000_0000, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("b2b_out_S2", out_S, 32'h8000_0000);
    chk("b2b_in_ready2", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_drained", out_valid, 0);
    chk("b2b_we_masked", out_we, 0);

    // Backpressure fills both entries; a third offer is refused.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h22, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_out_valid", out_valid, 1);
    chk("bp_full_out_S", out_S, 32'h11);
    drive(1'b1, 32'h33, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_hold_out_S", out_S, 32'h11);
    chk("bp_hold_in_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_skid_to_main", out_S, 32'h22);
    chk("bp_one_in_ready", in_ready, 1);
    tick();
    chk("bp_empty", out_valid, 0);

    // Simultaneous in/out handshake while holding one entry.
    out_ready = 1'b0;
    drive(1'b1, 32'hAA, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sim_hold_AA", out_S, 32'hAA);
    drive(1'b1, 32'hBB, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("sim_out_S", out_S, 32'hBB);
    chk("sim_out_valid", out_valid, 1);
    chk("sim_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("sim_empty", out_valid, 0);

    // Flush from FULL beats a concurrent input and output handshake.
    out_ready = 1'b0;
    drive(1'b1, 32'h01, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h02, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_full", in_ready, 0);
    drive(1'b1, 32'h03, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_out_we", out_we, 0);
    tick();
    tick();
    chk("fl_stays_empty", out_valid, 0);

    // Asynchronous reset between edges with two results held.
    out_ready = 1'b0;
    drive(1'b1, 32'h0A, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0B, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_we", out_we, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out_S", out_S, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h7, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_new_out_S", out_S, 32'h7);
    in_valid = 1'b0;
    tick();
    chk("rst_new_alone", out_valid, 0);

    // Flag forwarding depends on the build configuration.
    drive(1'b1, 32'h55, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("flag_V", out_V, FL);
    chk("flag_N", out_N, FL);
    chk("flag_C", out_C, 0);
    chk("flag_Z", out_Z, 0);
    in_valid = 1'b0;
    tick();
    tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
